// File: rtl/dca_lsu_rdata_gather.sv
// AXI read-data gatherer: packs NUM_BEAT R beats into one memory row and
// presents it downstream together with the transaction tag queued at AR time.
// Response errors and framing errors (early or missing rlast) mark the row.
module dca_lsu_rdata_gather #(
  parameter int BW_DATA              = 32,
  parameter int BW_MEMORY_ROW_BUFFER = 128,
  parameter int BW_TXN_INFO          = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic                            info_valid,
  output logic                            info_ready,
  input  logic [BW_TXN_INFO-1:0]          info,
  input  logic                            rvalid,
  output logic                            rready,
  input  logic [BW_DATA-1:0]              rdata,
  input  logic [1:0]                      rresp,
  input  logic                            rlast,
  output logic                            row_valid,
  input  logic                            row_ready,
  output logic [BW_MEMORY_ROW_BUFFER-1:0] row_data,
  output logic [BW_TXN_INFO-1:0]          row_info,
  output logic                            row_error,
  output logic                            err_sticky
);

  localparam int NUM_BEAT    = BW_MEMORY_ROW_BUFFER / BW_DATA;
  localparam int BW_BEAT_CNT = (NUM_BEAT > 1) ? $clog2(NUM_BEAT) : 1;
  localparam logic [BW_BEAT_CNT-1:0] LAST_BEAT = BW_BEAT_CNT'(NUM_BEAT - 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t                          state;
  logic [BW_TXN_INFO-1:0]          fifo_mem [2];
  logic                            wr_ptr;
  logic                            rd_ptr;
  logic [1:0]                      fifo_cnt;
  logic [BW_BEAT_CNT-1:0]          beat_cnt;
  logic [BW_MEMORY_ROW_BUFFER-1:0] row_buf;
  logic                            error_acc;
  logic                            err_flag;

  logic flush;
  logic push;
  logic pop;
  logic r_hs;
  logic final_beat;
  logic framing_err;
  logic end_row;

  assign flush       = rst | clear;
  assign info_ready  = (fifo_cnt != 2'd2);
  assign rready      = (state == COLLECT) && (fifo_cnt != 2'd0);
  assign row_valid   = (state == HOLD);
  assign row_data    = row_buf;
  assign row_info    = fifo_mem[rd_ptr];
  assign row_error   = (state == HOLD) && error_acc;
  assign err_sticky  = err_flag;

  assign push        = info_valid & info_ready;
  assign pop         = (state == HOLD) & row_ready;
  assign r_hs        = rvalid & rready;
  assign final_beat  = (beat_cnt == LAST_BEAT);
  // rlast must coincide exactly with the final slot; any disagreement is framing
  assign framing_err = r_hs & (final_beat != rlast);
  assign end_row     = r_hs & (final_beat | rlast);

  // Two-entry tag queue; a push and a pop in the same cycle leave occupancy unchanged
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= info;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Collect beats into the row buffer, then hold the row until downstream accepts it
  always_ff @(posedge clk) begin
    if (flush) begin
      state     <= COLLECT;
      beat_cnt  <= '0;
      row_buf   <= '0;
      error_acc <= 1'b0;
      err_flag  <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (r_hs) begin
            for (int k = 0; k < NUM_BEAT; k++) begin
              if (beat_cnt == BW_BEAT_CNT'(k)) begin
                row_buf[k*BW_DATA +: BW_DATA] <= rdata;
              end
            end
            error_acc <= error_acc | (rresp != 2'b00) | framing_err;
            if (framing_err) begin
              err_flag <= 1'b1;
            end
            if (end_row) begin
              state <= HOLD;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (row_ready) begin
            row_buf   <= '0;
            beat_cnt  <= '0;
            error_acc <= 1'b0;
            state     <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_dca_lsu_rdata_gather.sv
// Directed bench for dca_lsu_rdata_gather with a 32-bit beat and 128-bit row.
module tb_dca_lsu_rdata_gather;

  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic         info_valid;
  logic         info_ready;
  logic [7:0]   info;
  logic         rvalid;
  logic         rready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         row_valid;
  logic         row_ready;
  logic [127:0] row_data;
  logic [7:0]   row_info;
  logic         row_error;
  logic         err_sticky;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [7:0]       tag;
    logic [3:0][31:0] beats;
    logic [3:0][1:0]  resp;
    int               nbeats;
    int               last_idx;
    logic [127:0]     exp_data;
    logic             exp_err;
    logic             exp_sticky;
  } vec_t;

  vec_t vecs [5];
  vec_t v;

  dca_lsu_rdata_gather #(
    .BW_DATA(32),
    .BW_MEMORY_ROW_BUFFER(128),
    .BW_TXN_INFO(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .info_valid(info_valid),
    .info_ready(info_ready),
    .info(info),
    .rvalid(rvalid),
    .rready(rready),
    .rdata(rdata),
    .rresp(rresp),
    .rlast(rlast),
    .row_valid(row_valid),
    .row_ready(row_ready),
    .row_data(row_data),
    .row_info(row_info),
    .row_error(row_error),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_flush(input bit use_clear);
    info_valid = 1'b0;
    rvalid     = 1'b0;
    rlast      = 1'b0;
    rresp      = 2'b00;
    if (use_clear) clear = 1'b1;
    else           rst   = 1'b1;
    tick();
    rst   = 1'b0;
    clear = 1'b0;
  endtask

  task automatic push_tag(input logic [7:0] tag);
    info_valid = 1'b1;
    info       = tag;
    tick();
    info_valid = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t tv);
    for (int i = 0; i < tv.nbeats; i++) begin
      rvalid = 1'b1;
      rdata  = tv.beats[i];
      rresp  = tv.resp[i];
      rlast  = (i == tv.last_idx);
      check_output($sformatf("rready_beat%0d", i), 128'(rready), 128'(1));
      tick();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
  endtask

  // Expects row_ready already high: row shows for exactly one cycle
  task automatic check_row(input vec_t tv);
    check_output("row_valid", 128'(row_valid), 128'(1));
    check_output("row_data", row_data, tv.exp_data);
    check_output("row_info", 128'(row_info), 128'(tv.tag));
    check_output("row_error", 128'(row_error), 128'(tv.exp_err));
    check_output("err_sticky", 128'(err_sticky), 128'(tv.exp_sticky));
    tick();
    check_output("row_valid_drop", 128'(row_valid), 128'(0));
    check_output("err_sticky_after", 128'(err_sticky), 128'(tv.exp_sticky));
  endtask

  initial begin
    vecs[0] = '{tag: 8'h5A, beats: {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                resp: {2'd0, 2'd0, 2'd0, 2'd0}, nbeats: 4, last_idx: 3,
                exp_data: 128'h44444444_33333333_22222222_11111111, exp_err: 1'b0, exp_sticky: 1'b0};
    vecs[1] = '{tag: 8'h5A, beats: {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                resp: {2'd0, 2'd0, 2'd2, 2'd0}, nbeats: 4, last_idx: 3,
                exp_data: 128'h44444444_33333333_22222222_11111111, exp_err: 1'b1, exp_sticky: 1'b0};
    vecs[2] = '{tag: 8'h77, beats: {32'h0, 32'h0, 32'hBBBBBBBB, 32'hAAAAAAAA},
                resp: {2'd0, 2'd0, 2'd0, 2'd0}, nbeats: 2, last_idx: 1,
                exp_data: 128'h00000000_00000000_BBBBBBBB_AAAAAAAA, exp_err: 1'b1, exp_sticky: 1'b1};
    vecs[3] = '{tag: 8'hC3, beats: {32'hD4D4D4D4, 32'hC3C3C3C3, 32'hB2B2B2B2, 32'hA1A1A1A1},
                resp: {2'd0, 2'd0, 2'd0, 2'd0}, nbeats: 4, last_idx: -1,
                exp_data: 128'hD4D4D4D4_C3C3C3C3_B2B2B2B2_A1A1A1A1, exp_err: 1'b1, exp_sticky: 1'b1};
    vecs[4] = '{tag: 8'h26, beats: {32'h0, 32'h0, 32'h0, 32'h12345678},
                resp: {2'd0, 2'd0, 2'd0, 2'd3}, nbeats: 1, last_idx: 0,
                exp_data: 128'h00000000_00000000_00000000_12345678, exp_err: 1'b1, exp_sticky: 1'b1};

    rst        = 1'b1;
    clear      = 1'b0;
    info_valid = 1'b0;
    info       = 8'h00;
    rvalid     = 1'b0;
    rdata      = 32'h0;
    rresp      = 2'b00;
    rlast      = 1'b0;
    row_ready  = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_output("rst_info_ready", 128'(info_ready), 128'(1));
    check_output("rst_rready", 128'(rready), 128'(0));
    check_output("rst_row_valid", 128'(row_valid), 128'(0));
    check_output("rst_row_data", row_data, 128'h0);
    check_output("rst_row_info", 128'(row_info), 128'(0));
    check_output("rst_row_error", 128'(row_error), 128'(0));
    check_output("rst_err_sticky", 128'(err_sticky), 128'(0));

    // Table-driven rows, each from a fresh reset
    for (int n = 0; n < 5; n++) begin
      do_flush(1'b0);
      push_tag(vecs[n].tag);
      apply_stimulus(vecs[n]);
      check_row(vecs[n]);
    end

    // No tag queued: beats must be refused until a tag arrives
    do_flush(1'b0);
    rvalid = 1'b1;
    rdata  = 32'hDEADBEEF;
    rlast  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_output("notag_rready", 128'(rready), 128'(0));
      tick();
    end
    push_tag(8'h03);
    check_output("tag_rready", 128'(rready), 128'(1));
    v = '{tag: 8'h03, beats: {32'h04040404, 32'h03030303, 32'h02020202, 32'h01010101},
          resp: {2'd0, 2'd0, 2'd0, 2'd0}, nbeats: 4, last_idx: 3,
          exp_data: 128'h04040404_03030303_02020202_01010101, exp_err: 1'b0, exp_sticky: 1'b0};
    apply_stimulus(v);
    check_row(v);

    // Backpressure in HOLD with a second tag arriving
    do_flush(1'b0);
    row_ready = 1'b0;
    v = vecs[0];
    v.tag = 8'h24;
    push_tag(v.tag);
    apply_stimulus(v);
    rvalid     = 1'b1;
    rdata      = 32'hCAFEBABE;
    info_valid = 1'b1;
    info       = 8'h99;
    for (int i = 0; i < 5; i++) begin
      check_output("hold_rready", 128'(rready), 128'(0));
      check_output("hold_row_valid", 128'(row_valid), 128'(1));
      check_output("hold_row_data", row_data, v.exp_data);
      check_output("hold_row_info", 128'(row_info), 128'(8'h24));
      check_output("hold_info_ready", 128'(info_ready), 128'(i == 0));
      tick();
      info_valid = 1'b0;
    end
    row_ready = 1'b1;
    rvalid    = 1'b0;
    tick();
    check_output("pop_info_ready", 128'(info_ready), 128'(1));
    check_output("pop_row_valid", 128'(row_valid), 128'(0));
    check_output("pop_next_head", 128'(row_info), 128'(8'h99));
    check_output("pop_rready", 128'(rready), 128'(1));

    // Clear mid-row discards partial beats, queued tags and the sticky flag
    do_flush(1'b0);
    push_tag(vecs[4].tag);
    apply_stimulus(vecs[4]);
    check_row(vecs[4]);
    push_tag(8'h25);
    for (int i = 0; i < 2; i++) begin
      rvalid = 1'b1;
      rdata  = 32'hEEEE0000 + 32'(i);
      rlast  = 1'b0;
      tick();
    end
    rvalid = 1'b0;
    do_flush(1'b1);
    check_output("clr_row_valid", 128'(row_valid), 128'(0));
    check_output("clr_rready", 128'(rready), 128'(0));
    check_output("clr_info_ready", 128'(info_ready), 128'(1));
    check_output("clr_row_data", row_data, 128'h0);
    check_output("clr_err_sticky", 128'(err_sticky), 128'(0));
    tick();
    check_output("clr_no_row", 128'(row_valid), 128'(0));
    push_tag(vecs[0].tag);
    apply_stimulus(vecs[0]);
    check_row(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
